// File: rtl/if_id_buffer.sv
// if_id_buffer
// Decoupling FIFO between instruction fetch and decode.
// Fetch pushes {pc, inst} beats over a valid/ready handshake; decode pops
// the oldest beat over a second valid/ready handshake. Each entry carries
// predecode fields (opcode class, ebreak, illegal) computed at push time.
// A flush empties the FIFO and drops any beat offered in the same cycle.
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   in_valid/in_ready     fetch handshake; in_pc, in_inst beat payload
//   flush                 redirect, discards buffered and incoming beats
//   out_valid/out_ready   decode handshake; out_pc, out_inst head payload
//   out_class             predecoded opcode class of head (0 = unknown)
//   out_ebreak            head instruction is EBREAK
//   out_illegal           head opcode class is 0
//   count                 occupied entries
//   fetched               running count of accepted beats (wraps)
module if_id_buffer #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_inst,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_inst,
  output logic [3:0]                 out_class,
  output logic                       out_ebreak,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                fetched
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0] EBREAK_INST = 32'h00100073;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] inst_mem  [DEPTH];
  logic [3:0]      class_mem [DEPTH];
  logic            eb_mem    [DEPTH];
  logic            ill_mem   [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic       push;
  logic       pop;
  logic [3:0] in_class;
  logic       in_ebreak;

  function automatic logic [3:0] opcode_class(input logic [6:0] opc);
    case (opc)
      7'b0110111: opcode_class = 4'd1;
      7'b0010111: opcode_class = 4'd2;
      7'b1101111: opcode_class = 4'd3;
      7'b1100111: opcode_class = 4'd4;
      7'b1100011: opcode_class = 4'd5;
      7'b0000011: opcode_class = 4'd6;
      7'b0100011: opcode_class = 4'd7;
      7'b0010011: opcode_class = 4'd8;
      7'b0110011: opcode_class = 4'd9;
      7'b1110011: opcode_class = 4'd10;
      default:    opcode_class = 4'd0;
    endcase
  endfunction

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign in_class  = opcode_class(in_inst[6:0]);
  assign in_ebreak = (in_inst == XLEN'(EBREAK_INST));

  // Head fields come straight from entry storage; nothing is recomputed here.
  assign out_pc      = pc_mem[rd_ptr];
  assign out_inst    = inst_mem[rd_ptr];
  assign out_class   = class_mem[rd_ptr];
  assign out_ebreak  = eb_mem[rd_ptr];
  assign out_illegal = ill_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      fetched <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        inst_mem[i]  <= '0;
        class_mem[i] <= '0;
        eb_mem[i]    <= 1'b0;
        // Stored separately so a cleared entry does not read as illegal.
        ill_mem[i]   <= 1'b0;
      end
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= in_pc;
        inst_mem[wr_ptr]  <= in_inst;
        class_mem[wr_ptr] <= in_class;
        eb_mem[wr_ptr]    <= in_ebreak;
        ill_mem[wr_ptr]   <= (in_class == 4'd0);
        fetched           <= fetched + 32'd1;
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [3:0]  out_class;
  logic        out_ebreak;
  logic        out_illegal;
  logic [1:0]  count;
  logic [31:0] fetched;

  int total;
  int passed;

  if_id_buffer #(.DEPTH(2), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_class(out_class), .out_ebreak(out_ebreak), .out_illegal(out_illegal),
    .count(count), .fetched(fetched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r, iv, fl, ordy;
    logic [31:0] pc, inst;
    logic        e_ov, e_ir;
    logic [1:0]  e_cnt;
    logic [31:0] e_fet;
    logic        chk_data;
    logic [31:0] e_pc, e_inst;
    logic [3:0]  e_cls;
    logic        e_eb, e_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, iv, fl, ordy, input logic [31:0] pc, inst,
                     input logic e_ov, e_ir, input logic [1:0] e_cnt, input logic [31:0] e_fet,
                     input logic cd, input logic [31:0] e_pc, e_inst, input logic [3:0] e_cls,
                     input logic e_eb, e_ill);
    vec_t v;
    v.r = r; v.iv = iv; v.fl = fl; v.ordy = ordy; v.pc = pc; v.inst = inst;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_cnt = e_cnt; v.e_fet = e_fet;
    v.chk_data = cd; v.e_pc = e_pc; v.e_inst = e_inst; v.e_cls = e_cls;
    v.e_eb = e_eb; v.e_ill = e_ill;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic r, iv, fl, ordy, input logic [31:0] pc, inst);
    rst = r; in_valid = iv; flush = fl; out_ready = ordy; in_pc = pc; in_inst = inst;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Predecode table: instruction, class, ebreak, illegal
  logic [31:0] pd_inst [10];
  logic [3:0]  pd_cls  [10];
  logic        pd_eb   [10];
  logic        pd_ill  [10];

  initial begin
    total = 0;
    passed = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    pd_inst[0] = 32'h00100073; pd_cls[0] = 4'd10; pd_eb[0] = 1'b1; pd_ill[0] = 1'b0;
    pd_inst[1] = 32'hFFFFFFFF; pd_cls[1] = 4'd0;  pd_eb[1] = 1'b0; pd_ill[1] = 1'b1;
    pd_inst[2] = 32'h00000097; pd_cls[2] = 4'd2;  pd_eb[2] = 1'b0; pd_ill[2] = 1'b0;
    pd_inst[3] = 32'h0000006F; pd_cls[3] = 4'd3;  pd_eb[3] = 1'b0; pd_ill[3] = 1'b0;
    pd_inst[4] = 32'h00008067; pd_cls[4] = 4'd4;  pd_eb[4] = 1'b0; pd_ill[4] = 1'b0;
    pd_inst[5] = 32'h00000063; pd_cls[5] = 4'd5;  pd_eb[5] = 1'b0; pd_ill[5] = 1'b0;
    pd_inst[6] = 32'h00002003; pd_cls[6] = 4'd6;  pd_eb[6] = 1'b0; pd_ill[6] = 1'b0;
    pd_inst[7] = 32'h00002023; pd_cls[7] = 4'd7;  pd_eb[7] = 1'b0; pd_ill[7] = 1'b0;
    pd_inst[8] = 32'h00000033; pd_cls[8] = 4'd9;  pd_eb[8] = 1'b0; pd_ill[8] = 1'b0;
    pd_inst[9] = 32'h00000073; pd_cls[9] = 4'd10; pd_eb[9] = 1'b0; pd_ill[9] = 1'b0;

    // Reset held two cycles, then idle.
    add(0,0,0,0, 32'h0, 32'h0, 0,1,2'd0, 32'd0, 1, 32'h0, 32'h0, 4'd0, 0,0);
    add(0,0,0,0, 32'h0, 32'h0, 0,1,2'd0, 32'd0, 1, 32'h0, 32'h0, 4'd0, 0,0);
    add(1,0,0,0, 32'h0, 32'h0, 0,1,2'd0, 32'd0, 1, 32'h0, 32'h0, 4'd0, 0,0);
    // Single beat, then pop.
    add(1,1,0,0, 32'h80000000, 32'h00000413, 1,1,2'd1, 32'd1, 1, 32'h80000000, 32'h00000413, 4'd8, 0,0);
    add(1,0,0,1, 32'h0, 32'h0, 0,1,2'd0, 32'd1, 0, 32'h0, 32'h0, 4'd0, 0,0);
    // Fill, refused third beat with head stable, drain in order.
    add(1,1,0,0, 32'h80000000, 32'h00000413, 1,1,2'd1, 32'd2, 1, 32'h80000000, 32'h00000413, 4'd8, 0,0);
    add(1,1,0,0, 32'h80000004, 32'h12345037, 1,0,2'd2, 32'd3, 1, 32'h80000000, 32'h00000413, 4'd8, 0,0);
    add(1,1,0,0, 32'h80000008, 32'h00000013, 1,0,2'd2, 32'd3, 1, 32'h80000000, 32'h00000413, 4'd8, 0,0);
    add(1,0,0,1, 32'h0, 32'h0, 1,1,2'd1, 32'd3, 1, 32'h80000004, 32'h12345037, 4'd1, 0,0);
    add(1,0,0,1, 32'h0, 32'h0, 0,1,2'd0, 32'd3, 0, 32'h0, 32'h0, 4'd0, 0,0);
    // Predecode: each row pushes while the previous entry is popped.
    for (int k = 0; k < 10; k++)
      add(1,1,0,1, 32'h100 + 32'(4*k), pd_inst[k], 1,1,2'd1, 32'd4 + 32'(k), 1,
          32'h100 + 32'(4*k), pd_inst[k], pd_cls[k], pd_eb[k], pd_ill[k]);
    add(1,0,0,1, 32'h0, 32'h0, 0,1,2'd0, 32'd13, 0, 32'h0, 32'h0, 4'd0, 0,0);

    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].iv, vecs[i].fl, vecs[i].ordy, vecs[i].pc, vecs[i].inst);
      tick();
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
      chk($sformatf("v%0d count", i),     32'(count),     32'(vecs[i].e_cnt));
      chk($sformatf("v%0d fetched", i),   fetched,        vecs[i].e_fet);
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d out_pc", i),      out_pc,             vecs[i].e_pc);
        chk($sformatf("v%0d out_inst", i),    out_inst,           vecs[i].e_inst);
        chk($sformatf("v%0d out_class", i),   32'(out_class),     32'(vecs[i].e_cls));
        chk($sformatf("v%0d out_ebreak", i),  32'(out_ebreak),    32'(vecs[i].e_eb));
        chk($sformatf("v%0d out_illegal", i), 32'(out_illegal),   32'(vecs[i].e_ill));
      end
    end

    // Concurrent push/pop at count=1 over 8 cycles; pointers wrap several times.
    drive(1, 1, 0, 0, 32'h200, 32'h00000013);
    tick();
    chk("cc start count", 32'(count), 32'd1);
    chk("cc start pc", out_pc, 32'h200);
    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 0, 1, 32'h200 + 32'(4*i), 32'h00000013);
      tick();
      chk($sformatf("cc%0d count", i), 32'(count), 32'd1);
      chk($sformatf("cc%0d out_pc", i), out_pc, 32'h200 + 32'(4*i));
    end
    drive(1, 0, 0, 1, 32'h0, 32'h0);
    tick();
    chk("cc drain out_valid", 32'(out_valid), 32'd0);
    chk("cc fetched", fetched, 32'd22);

    // Flush at count=2 with a beat offered, then at count=0 with an acceptable beat.
    drive(1, 1, 0, 0, 32'h400, 32'h00000013);
    tick();
    drive(1, 1, 0, 0, 32'h404, 32'h00000013);
    tick();
    chk("fl pre count", 32'(count), 32'd2);
    drive(1, 1, 1, 1, 32'hDEAD0000, 32'h00000013);
    tick();
    chk("fl count", 32'(count), 32'd0);
    chk("fl out_valid", 32'(out_valid), 32'd0);
    chk("fl in_ready", 32'(in_ready), 32'd1);
    chk("fl fetched", fetched, 32'd24);
    drive(1, 1, 1, 0, 32'hDEAD0004, 32'h00000013);
    tick();
    chk("fl drop count", 32'(count), 32'd0);
    chk("fl drop fetched", fetched, 32'd24);
    drive(1, 1, 0, 0, 32'h500, 32'h00000033);
    tick();
    chk("fl after out_valid", 32'(out_valid), 32'd1);
    chk("fl after out_pc", out_pc, 32'h500);
    chk("fl after class", 32'(out_class), 32'd9);
    chk("fl after fetched", fetched, 32'd25);
    drive(1, 0, 0, 1, 32'h0, 32'h0);
    tick();
    chk("fl after pop", 32'(out_valid), 32'd0);

    // Reset mid-run with count=2, overriding push, pop and flush.
    drive(1, 1, 0, 0, 32'h600, 32'h00100073);
    tick();
    drive(1, 1, 0, 0, 32'h604, 32'h00000013);
    tick();
    chk("rs pre count", 32'(count), 32'd2);
    drive(0, 1, 1, 1, 32'h608, 32'h00000013);
    tick();
    chk("rs count", 32'(count), 32'd0);
    chk("rs out_valid", 32'(out_valid), 32'd0);
    chk("rs in_ready", 32'(in_ready), 32'd1);
    chk("rs fetched", fetched, 32'd0);
    chk("rs out_pc", out_pc, 32'h0);
    chk("rs out_inst", out_inst, 32'h0);
    chk("rs out_ebreak", 32'(out_ebreak), 32'd0);
    chk("rs out_illegal", 32'(out_illegal), 32'd0);
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    tick();
    chk("rs idle out_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Decoupling buffer between the instruction fetch stage and the decode stage.
- Accepts {pc, inst} beats from fetch over a valid/ready handshake and holds them in a small in-order FIFO.
- Presents the oldest beat to decode over a second valid/ready handshake, with registered predecode fields.
- Supports a synchronous flush for redirects (branch/jump/trap) and keeps a count of accepted instructions for performance reporting.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, at least 2.
- XLEN, 32, width of pc and inst.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- in_valid  input  1  fetch presents a beat.
- in_ready  output  1  buffer can accept a beat this cycle.
- in_pc  input  XLEN  pc of the fetched instruction.
- in_inst  input  XLEN  fetched instruction word.
- flush  input  1  redirect; discard all buffered and incoming beats.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  XLEN  pc of the head entry.
- out_inst  output  XLEN  instruction of the head entry.
- out_class  output  4  predecoded opcode class of the head entry.
- out_ebreak  output  1  head instruction equals 32'h00100073.
- out_illegal  output  1  head out_class == 0.
- count  output  $clog2(DEPTH)+1  number of occupied entries.
- fetched  output  32  running count of accepted beats.

Behaviour:
- Reset (rst==0 at a rising edge):
  - Read pointer, write pointer and count go to 0; fetched goes to 0.
  - All storage is cleared to 0, so out_pc, out_inst, out_class, out_ebreak and out_illegal read 0.
  - out_valid is 0 and in_ready is 1 from the first cycle after reset.
  - Reset overrides flush, push and pop, including when asserted mid-operation.
- Handshake signals:
  - in_ready = (count < DEPTH). It is combinational from count only and does not depend on out_ready. There is no pass-through when the buffer is full.
  - push = in_valid & in_ready & ~flush.
  - out_valid = (count != 0).
  - pop = out_valid & out_ready & ~flush.
- Latency:
  - A beat pushed at edge N appears on out_* in the cycle after edge N. There is no combinational bypass from in_* to out_*.
  - Minimum in-to-out latency is 1 cycle.
- Simultaneous push and pop (count between 1 and DEPTH-1): both take effect, count is unchanged, and pointers advance.
- Push with count == DEPTH is impossible because in_ready is 0. A pop with count == 0 is ignored.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. Entries leave in strict arrival order.
- Flush:
  - When flush==1 at an edge, pointers and count go to 0 and out_valid is 0 in the next cycle.
  - A beat offered in the same cycle is dropped and not counted in fetched.
  - Storage contents are not cleared; out_* data fields are don't-care while out_valid==0.
  - Flush takes priority over push and pop.
- out_* data must be stable while out_valid==1 and out_ready==0.
- Predecode:
  - Computed from in_inst[6:0] at push and stored alongside the entry (registered, not recomputed at the head).
  - Class encoding:
    - 0110111 -> 1 (LUI)
    - 0010111 -> 2 (AUIPC)
    - 1101111 -> 3 (JAL)
    - 1100111 -> 4 (JALR)
    - 1100011 -> 5 (BRANCH)
    - 0000011 -> 6 (LOAD)
    - 0100011 -> 7 (STORE)
    - 0010011 -> 8 (OP-IMM)
    - 0110011 -> 9 (OP)
    - 1110011 -> 10 (SYSTEM)
    - any other opcode -> 0
  - The ebreak bit is stored per entry as well.
- fetched:
  - Increments by 1 on every push and wraps from 32'hFFFFFFFF to 0.
  - It is not cleared by flush.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release -> count=0, out_valid=0, in_ready=1, fetched=0, out_pc=0, out_inst=0.
- Single beat: push pc=32'h80000000, inst=32'h00000413 with out_ready=0 -> next cycle out_valid=1, out_pc=32'h80000000, out_class=8, count=1; assert out_ready -> out_valid=0 the cycle after.
- Fill and order: out_ready=0, push pc 0x80000000 then 0x80000004 -> count=2, in_ready=0; a third in_valid is not accepted; drain -> out_pc sequence 0x80000000, 0x80000004; fetched=2.
- Concurrent push/pop at count=1 over 8 cycles with incrementing pc -> count stays 1, out_pc advances by 4 each cycle, pointers wrap without loss.
- Flush with simultaneous push at count=2 -> next cycle count=0, out_valid=0, fetched unchanged, dropped pc never appears on out_pc.
- Predecode and reset mid-run:
  - push 32'h00100073 -> out_ebreak=1, out_class=10.
  - push 32'hFFFFFFFF -> out_illegal=1.
  - pull rst low with count=2 -> next cycle count=0, fetched=0.
